inter_stage_buf: RTL and testbench
==================================

INTER_STAGE_BUF -- requirements
Module: inter_stage_buf

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 - C_S_AXIS_DATA_WIDTH, 512, control-path AXIS data width
 - C_S_AXIS_TUSER_WIDTH, 128, control-path AXIS tuser width
 - PHV_LEN, 1024, PHV width in bits
 - DEPTH, 4, PHV entries; power of two, at least 4
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
 - clk, in, 1, sole clock
 - rst, in, 1, synchronous, active-high reset
 - phv_in, in, PHV_LEN, PHV from the upstream stage phv_out
 - phv_in_valid, in, 1, one-cycle pulse per PHV
 - ready_out, out, 1, level; drives the upstream stage_ready_in
 - phv_out, out, PHV_LEN, PHV to the downstream stage phv_in
 - phv_out_valid, out, 1, one-cycle pulse per PHV
 - ready_in, in, 1, level from the downstream stage_ready_out
 - c_s_axis_tdata/tuser/tkeep/tvalid/tlast, in, DATA/TUSER/DATA/8/1/1, control path from upstream
 - c_m_axis_tdata/tuser/tkeep/tvalid/tlast, out, same widths, control path to downstream
 - overflow, out, 1, sticky flag: a PHV was dropped
 - drop_cnt, out, 16, count of dropped PHVs

Function
REQ-003 Storage SHALL be a DEPTH-entry circular FIFO with write pointer wr_ptr, read pointer rd_ptr, and occupancy count (0..DEPTH).
REQ-004 Pointers SHALL wrap modulo DEPTH; DEPTH-1 plus 1 SHALL equal 0.
REQ-005 pop SHALL equal ready_in AND (count > 0), evaluated on the pre-edge count.
REQ-006 push SHALL equal phv_in_valid AND ((count < DEPTH) OR pop).
REQ-007 On push, phv_in SHALL be written at wr_ptr and wr_ptr SHALL increment.
REQ-008 On pop, the entry at rd_ptr SHALL be registered into phv_out, phv_out_valid SHALL be 1 for the next cycle, and rd_ptr SHALL increment.
REQ-009 phv_out_valid SHALL be 0 in every cycle not following a pop.
REQ-010 phv_out SHALL hold its last value when phv_out_valid is 0.
REQ-011 count SHALL update as: +1 on push only; -1 on pop only; unchanged on push and pop together or on neither.
REQ-012 Empty FIFO, phv_in_valid at cycle N, ready_in high: phv_out_valid SHALL assert at cycle N+2; there is no bypass path.
REQ-013 Steady throughput with ready_in held high SHALL be one PHV per cycle.
REQ-014 ready_out SHALL be combinational, equal to (count <= DEPTH-2), giving at least two free slots for an in-flight upstream pulse.
REQ-015 phv_in_valid with count == DEPTH and no pop: the PHV SHALL be discarded, FIFO state SHALL be unchanged, overflow SHALL be set, and drop_cnt SHALL increment, saturating at 16'hFFFF.
REQ-016 overflow SHALL clear only on rst.
REQ-017 Order SHALL be preserved; no PHV SHALL be duplicated.
REQ-018 Control path: every c_m_axis_* output SHALL be a 1-cycle registered copy of the matching c_s_axis_* input, with no backpressure, independent of PHV traffic.
REQ-019 A control beat and a PHV in the same cycle SHALL both be handled with no interaction.

Reset
REQ-020 While rst is high at a clk edge, the block SHALL set wr_ptr, rd_ptr and count to 0.
REQ-021 Reset SHALL also clear phv_out, phv_out_valid, overflow, drop_cnt and all c_m_axis_* to 0.
REQ-022 Reset SHALL take effect mid-operation: stored PHVs SHALL be discarded and no phv_out_valid SHALL follow from pre-reset contents.
REQ-023 Inputs SHALL be ignored during the cycle rst is sampled high.
REQ-024 ready_out SHALL read 1 from the first cycle after reset.

Verification
REQ-025 Single pass: after reset, ready_in=1, pulse phv_in=1024'hA5 at cycle 10 -> phv_out_valid=1 at cycle 12 only, phv_out=1024'hA5, ready_out stays 1.
REQ-026 Backpressure fill: ready_in=0, pulses with values 1,2,3,4 on consecutive cycles -> ready_out=1 while count<=2, ready_out=0 once count=3; count reaches 4; nothing is dropped and overflow=0.
REQ-027 Overflow: FIFO full (count=4), ready_in=0, pulse value 5 -> overflow=1, drop_cnt=1; ready_in=1 then drains 1,2,3,4 on 4 consecutive phv_out_valid cycles, and 5 never appears.
REQ-028 Full with simultaneous push and pop: count=4, ready_in=1, pulse value 9 -> value 9 is accepted, count stays 4, drop_cnt is unchanged, and 9 appears after the three older entries.
REQ-029 Wrap-around and throughput: 20 back-to-back pulses, values 0..19, ready_in=1 -> 20 outputs in order with no gaps after the first, and pointers wrap 5 times.
REQ-030 Reset mid-stream and control path: count=3, assert rst for 1 cycle -> phv_out_valid=0 and no stale data afterwards; c_s_axis_tvalid=1 with tdata=512'h1234 and tlast=1 at cycle N -> c_m_axis_* equal those values at cycle N+1 only.

Source files
------------

// File: rtl/inter_stage_buf.sv
// Elastic PHV buffer placed between two pipeline stages, with a registered
// pass-through for the AXIS control path and drop accounting on overflow.
module inter_stage_buf #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int PHV_LEN              = 1024,
    parameter int DEPTH                = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PHV_LEN-1:0]                   phv_in,
    input  logic                                 phv_in_valid,
    output logic                                 ready_out,
    output logic [PHV_LEN-1:0]                   phv_out,
    output logic                                 phv_out_valid,
    input  logic                                 ready_in,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_s_axis_tkeep,
    input  logic                                 c_s_axis_tvalid,
    input  logic                                 c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
    output logic                                 c_m_axis_tvalid,
    output logic                                 c_m_axis_tlast,
    output logic                                 overflow,
    output logic [15:0]                          drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_READY = CW'(DEPTH - 2);

    logic [PHV_LEN-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;

    // Handshake decode from the pre-edge occupancy; a full FIFO still accepts when it pops.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        drop_s = 1'b0;
        if (rst) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
            drop_s = 1'b0;
        end else begin
            pop_s  = ready_in && (count_r != {CW{1'b0}});
            push_s = phv_in_valid && ((count_r < CNT_FULL) || pop_s);
            drop_s = phv_in_valid && !push_s;
        end
    end

    // Two free slots cover a pulse already in flight from the upstream stage.
    assign ready_out = (count_r <= CNT_READY);

    // Entry storage; pointers are reset so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= phv_in;
        end
    end

    // Pointers, occupancy, output register and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            count_r       <= {CW{1'b0}};
            phv_out       <= {PHV_LEN{1'b0}};
            phv_out_valid <= 1'b0;
            overflow      <= 1'b0;
            drop_cnt      <= 16'h0000;
        end else begin
            phv_out_valid <= pop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                phv_out  <= mem_r[rd_ptr_r];
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'h0001;
                end
            end
        end
    end

    // Control path: plain one-cycle register stage, no backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_m_axis_tdata  <= {C_S_AXIS_DATA_WIDTH{1'b0}};
            c_m_axis_tuser  <= {C_S_AXIS_TUSER_WIDTH{1'b0}};
            c_m_axis_tkeep  <= {(C_S_AXIS_DATA_WIDTH/8){1'b0}};
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end else begin
            c_m_axis_tdata  <= c_s_axis_tdata;
            c_m_axis_tuser  <= c_s_axis_tuser;
            c_m_axis_tkeep  <= c_s_axis_tkeep;
            c_m_axis_tvalid <= c_s_axis_tvalid;
            c_m_axis_tlast  <= c_s_axis_tlast;
        end
    end

endmodule

// File: tb/tb_inter_stage_buf.sv
// Self-checking bench for inter_stage_buf: directed scenarios plus random
// traffic compared against a queue-based model of the buffer.
module tb_inter_stage_buf;

    localparam int W = 512;
    localparam int U = 128;
    localparam int P = 1024;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [P-1:0]   phv_in;
    logic           phv_in_valid;
    logic           ready_out;
    logic [P-1:0]   phv_out;
    logic           phv_out_valid;
    logic           ready_in;
    logic [W-1:0]   c_s_axis_tdata;
    logic [U-1:0]   c_s_axis_tuser;
    logic [W/8-1:0] c_s_axis_tkeep;
    logic           c_s_axis_tvalid;
    logic           c_s_axis_tlast;
    logic [W-1:0]   c_m_axis_tdata;
    logic [U-1:0]   c_m_axis_tuser;
    logic [W/8-1:0] c_m_axis_tkeep;
    logic           c_m_axis_tvalid;
    logic           c_m_axis_tlast;
    logic           overflow;
    logic [15:0]    drop_cnt;

    inter_stage_buf #(
        .C_S_AXIS_DATA_WIDTH (W),
        .C_S_AXIS_TUSER_WIDTH(U),
        .PHV_LEN             (P),
        .DEPTH               (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .phv_in         (phv_in),
        .phv_in_valid   (phv_in_valid),
        .ready_out      (ready_out),
        .phv_out        (phv_out),
        .phv_out_valid  (phv_out_valid),
        .ready_in       (ready_in),
        .c_s_axis_tdata (c_s_axis_tdata),
        .c_s_axis_tuser (c_s_axis_tuser),
        .c_s_axis_tkeep (c_s_axis_tkeep),
        .c_s_axis_tvalid(c_s_axis_tvalid),
        .c_s_axis_tlast (c_s_axis_tlast),
        .c_m_axis_tdata (c_m_axis_tdata),
        .c_m_axis_tuser (c_m_axis_tuser),
        .c_m_axis_tkeep (c_m_axis_tkeep),
        .c_m_axis_tvalid(c_m_axis_tvalid),
        .c_m_axis_tlast (c_m_axis_tlast),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: a queue of stored PHVs plus expected outputs.
    logic [P-1:0]   q [$];
    logic           m_vld;
    logic [P-1:0]   m_out;
    logic           m_ovf;
    logic [15:0]    m_drop;
    logic [W-1:0]   m_tdata;
    logic [U-1:0]   m_tuser;
    logic [W/8-1:0] m_tkeep;
    logic           m_tvalid;
    logic           m_tlast;
    bit             m_known = 1'b0;
    int             n_out   = 0;

    task automatic check(input string tag, input logic [P-1:0] got, input logic [P-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        phv_in          = '0;
        phv_in_valid    = 1'b0;
        c_s_axis_tdata  = '0;
        c_s_axis_tuser  = '0;
        c_s_axis_tkeep  = '0;
        c_s_axis_tvalid = 1'b0;
        c_s_axis_tlast  = 1'b0;
    endtask

    // Advance one clock: predict from the current inputs, then compare after the edge.
    task automatic step();
        bit pop;
        bit push;
        if (m_known) begin
            check("ready_out", P'(ready_out), P'(q.size() <= D - 2));
        end
        if (rst) begin
            q.delete();
            m_vld = 1'b0; m_out = '0; m_ovf = 1'b0; m_drop = 16'h0000;
            m_tdata = '0; m_tuser = '0; m_tkeep = '0; m_tvalid = 1'b0; m_tlast = 1'b0;
        end else begin
            pop  = ready_in && (q.size() > 0);
            push = phv_in_valid && ((q.size() < D) || pop);
            m_vld = pop;
            if (pop) begin
                m_out = q.pop_front();
            end
            if (push) begin
                q.push_back(phv_in);
            end else if (phv_in_valid) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'h0001;
            end
            m_tdata = c_s_axis_tdata; m_tuser = c_s_axis_tuser; m_tkeep = c_s_axis_tkeep;
            m_tvalid = c_s_axis_tvalid; m_tlast = c_s_axis_tlast;
        end
        @(posedge clk);
        #1;
        if (rst) m_known = 1'b1;
        if (phv_out_valid === 1'b1) n_out++;
        check("phv_out_valid", P'(phv_out_valid), P'(m_vld));
        check("phv_out", phv_out, m_out);
        check("overflow", P'(overflow), P'(m_ovf));
        check("drop_cnt", P'(drop_cnt), P'(m_drop));
        check("c_m_axis_tdata", P'(c_m_axis_tdata), P'(m_tdata));
        check("c_m_axis_tuser", P'(c_m_axis_tuser), P'(m_tuser));
        check("c_m_axis_tkeep", P'(c_m_axis_tkeep), P'(m_tkeep));
        check("c_m_axis_tvalid", P'(c_m_axis_tvalid), P'(m_tvalid));
        check("c_m_axis_tlast", P'(c_m_axis_tlast), P'(m_tlast));
    endtask

    task automatic pulse(input logic [P-1:0] v);
        phv_in = v; phv_in_valid = 1'b1;
        step();
        phv_in = '0; phv_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ready_in = 1'b0;
        idle_inputs();
        phv_in_valid = 1'b1; phv_in = P'(64'hDEAD);
        c_s_axis_tvalid = 1'b1;
        step();
        step();
        idle_inputs();
        rst = 1'b0;

        // Single pass: one PHV with the consumer ready, two-cycle latency.
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) step();
        pulse(P'(8'hA5));
        check("single_n1_valid", P'(phv_out_valid), P'(1'b0));
        step();
        check("single_n2_valid", P'(phv_out_valid), P'(1'b1));
        check("single_n2_data", phv_out, P'(8'hA5));
        step();
        check("single_n3_valid", P'(phv_out_valid), P'(1'b0));

        // Backpressure fill, then overflow on the fifth pulse.
        ready_in = 1'b0;
        for (int v = 1; v <= 4; v++) pulse(P'(v));
        check("fill_ready_low", P'(ready_out), P'(1'b0));
        check("fill_no_overflow", P'(overflow), P'(1'b0));
        pulse(P'(5));
        check("ovf_flag", P'(overflow), P'(1'b1));
        check("ovf_drop_cnt", P'(drop_cnt), P'(16'd1));
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("ovf_sticky", P'(overflow), P'(1'b1));

        // Full FIFO with simultaneous push and pop.
        ready_in = 1'b0;
        for (int v = 6; v <= 9; v++) pulse(P'(v + 16));
        ready_in = 1'b1;
        pulse(P'(9));
        check("full_pp_drop_cnt", P'(drop_cnt), P'(16'd1));
        for (int i = 0; i < 6; i++) step();

        // Wrap-around at full throughput.
        n_out = 0;
        for (int v = 0; v < 20; v++) pulse(P'(v));
        for (int i = 0; i < 4; i++) step();
        check("wrap_out_count", P'(n_out), P'(20));

        // Reset with three stored entries, then a control beat.
        ready_in = 1'b0;
        for (int v = 0; v < 3; v++) pulse(P'(v + 100));
        do_reset();
        ready_in = 1'b1;
        n_out = 0;
        for (int i = 0; i < 4; i++) step();
        check("rst_no_stale", P'(n_out), P'(0));
        c_s_axis_tvalid = 1'b1; c_s_axis_tdata = W'(16'h1234); c_s_axis_tlast = 1'b1;
        step();
        idle_inputs();
        check("ctl_beat_valid", P'(c_m_axis_tvalid), P'(1'b1));
        check("ctl_beat_data", P'(c_m_axis_tdata), P'(16'h1234));
        step();
        check("ctl_beat_gone", P'(c_m_axis_tvalid), P'(1'b0));

        // Random traffic, including backpressure bursts and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            phv_in_valid = ($urandom_range(0, 2) != 0);
            phv_in = phv_in_valid ? P'({$urandom, $urandom}) : '0;
            ready_in = ((i / 64) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            c_s_axis_tvalid = $urandom_range(0, 1);
            c_s_axis_tlast = $urandom_range(0, 1);
            c_s_axis_tdata = {16{$urandom}};
            c_s_axis_tuser = {4{$urandom}};
            c_s_axis_tkeep = {$urandom, $urandom};
            rst = ($urandom_range(0, 299) == 0);
            step();
            rst = 1'b0;
        end
        idle_inputs();
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
